sprite_table: RTL and testbench
===============================

Name: sprite_table

Overview:
- Avalon-MM slave holding the frame's sprite list.
- Software writes entries into a shadow table, then requests a commit.
- At the next vertical-blank entry, the whole shadow table is copied in one cycle into the active table. The active table drives SPRITE_CONTROLLER's gl_array input directly.
- Guarantees tear-free sprite updates and provides a frame counter and an optional frame interrupt.

Parameters:
- NUM_SPRITES, 20, number of sprite entries (active and shadow tables each hold this many).
- V_ACTIVE, 480, first VGA_VCOUNT value that is vertical blank.

Ports:
- clk  in  1  system clock (50 MHz); every register is clocked on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- chipselect  in  1  Avalon slave select.
- write  in  1  Avalon write strobe.
- read  in  1  Avalon read strobe.
- address  in  5  word address.
- writedata  in  32  write data.
- readdata  out  32  read data, registered, read latency 1.
- VGA_VCOUNT  in  10  current scan line from the VGA timing generator.
- gl_array  out  24 x NUM_SPRITES  active sprite table, entry format [23:14] x, [13:5] y, [4:0] type (type 0 = disabled).
- frame_count  out  16  count of vblank entries, wraps 0xFFFF->0.
- irq  out  1  frame interrupt, level, sticky.

Behaviour:
- Reset (reset=0, async):
  - gl_array, shadow, readdata, frame_count: all 0.
  - pending=0, irq=0, irq_en=0.
  - vb_q=1, so no vblank edge can be detected until the scan returns to active video.
- Register map (access = chipselect & write, or chipselect & read):
  - 0..NUM_SPRITES-1 SHADOW[i]:
    - write: shadow[i] <= writedata[23:0].
    - read: {8'h00, shadow[i]}.
  - 20 CTRL, write:
    - bit0=1 sets pending.
    - bit1=1 zeroes all shadow entries in that cycle.
    - bit2 loads irq_en.
  - 20 CTRL, read: {29'b0, irq_en, 1'b0, pending}.
  - 21 STATUS, read: {frame_count, 14'b0, irq, pending}. The read clears irq.
  - 21 STATUS, write: bit0=1 clears irq.
  - 22..31: reads return 0, writes ignored.
- Read path: readdata is updated the cycle after chipselect & read, and holds its value otherwise. write & read together is illegal; write takes priority.
- Vblank edge detection:
  - in_vb = (VGA_VCOUNT >= V_ACTIVE); vb_q <= in_vb every cycle.
  - vb_edge = in_vb & ~vb_q, which is exactly one cycle per frame.
- On vb_edge:
  - frame_count += 1, unconditionally.
  - If pending (registered value): gl_array <= shadow (all entries, same cycle), pending <= 0, and irq <= 1 if irq_en.
- Simultaneous events:
  - CTRL commit write on the vb_edge cycle: the swap uses the old pending (0), so the commit takes effect at the next frame; pending ends the cycle at 1.
  - Shadow write on the swap cycle: gl_array receives the pre-write shadow value; the write lands in shadow only.
  - Commit and clear in one write: shadow is zeroed and pending is set; the next swap loads all zeros.
  - irq set and clear in the same cycle: set wins.
- gl_array never changes except on a swap or on reset. It is stable throughout active video.
- Reset mid-frame: state is cleared, and no swap occurs until in_vb falls and rises again.

Test Plan:
- Reset then idle for 2 frames (VCOUNT sweeping 0..524):
  - gl_array all 0, frame_count=2, irq=0.
  - STATUS read returns 0x00020000.
- Write SHADOW[3]=0x12345A, no commit, run 1 frame:
  - gl_array[3]=0.
  - Read addr 3 returns 0x0012345A, one cycle after the read strobe.
- Write SHADOW[0]=0x0A0281 and SHADOW[19]=0xFFFFFF, then CTRL=0x5, with VCOUNT at 100:
  - gl_array unchanged until VCOUNT reaches 480.
  - Then, in one cycle: gl_array[0]=0x0A0281, gl_array[19]=0xFFFFFF, pending=0, irq=1.
  - A STATUS read returns bit1=1, and the following read returns bit1=0.
- CTRL=0x1 written exactly on the vb_edge cycle:
  - No swap that frame; CTRL read returns pending=1.
  - Swap happens at the next vblank edge.
- CTRL=0x3 after populating the shadow, then one frame:
  - All gl_array entries 0.
  - SHADOW reads return 0.
- Assert reset=0 while VCOUNT=490 and pending=1, release it mid-vblank:
  - Outputs are 0.
  - No frame_count increment until after the next active-video-to-vblank transition.

Source files
------------

// File: rtl/sprite_table.sv
// Double-buffered sprite list: software fills a shadow table, which is swapped into gl_array at vblank entry.
// Avalon reads return one cycle after the strobe; no wait states or backpressure.
module sprite_table #(
  parameter int NUM_SPRITES = 20,
  parameter int V_ACTIVE    = 480
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              chipselect,
  input  logic                              write,
  input  logic                              read,
  input  logic [4:0]                        address,
  input  logic [31:0]                       writedata,
  output logic [31:0]                       readdata,
  input  logic [9:0]                        VGA_VCOUNT,
  output logic [NUM_SPRITES-1:0][23:0]      gl_array,
  output logic [15:0]                       frame_count,
  output logic                              irq
);

  localparam int          IW          = $clog2(NUM_SPRITES);
  localparam logic [4:0]  CTRL_ADDR   = 5'd20;
  localparam logic [4:0]  STATUS_ADDR = 5'd21;
  localparam logic [9:0]  VB_START    = 10'(V_ACTIVE);

  logic [NUM_SPRITES-1:0][23:0] shadow;
  logic                         pending;
  logic                         irq_en;
  logic                         vb_q;
  logic                         in_vb;
  logic                         vb_edge;
  logic                         bus_wr;
  logic                         bus_rd;
  logic                         is_shadow;
  logic [31:0]                  rd_mux;
  logic                         unused_wdata;

  assign in_vb        = (VGA_VCOUNT >= VB_START);
  assign vb_edge      = in_vb & ~vb_q;
  assign bus_wr       = chipselect & write;
  assign bus_rd       = chipselect & read & ~write;
  assign is_shadow    = (int'(address) < NUM_SPRITES);
  assign unused_wdata = ^writedata[31:24];

  always_comb begin
    rd_mux = '0;
    if (is_shadow)
      rd_mux = {8'h00, shadow[address[IW-1:0]]};
    else if (address == CTRL_ADDR)
      rd_mux = {29'b0, irq_en, 1'b0, pending};
    else if (address == STATUS_ADDR)
      rd_mux = {frame_count, 14'b0, irq, pending};
  end

  // Assignment order matters: a commit write on the swap cycle must leave
  // pending set, and an irq set on the swap cycle must beat any clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gl_array    <= '0;
      shadow      <= '0;
      readdata    <= '0;
      frame_count <= '0;
      pending     <= 1'b0;
      irq         <= 1'b0;
      irq_en      <= 1'b0;
      vb_q        <= 1'b1;
    end else begin
      vb_q <= in_vb;

      if (vb_edge) begin
        frame_count <= frame_count + 16'd1;
        if (pending) begin
          gl_array <= shadow;
          pending  <= 1'b0;
        end
      end

      if (bus_wr) begin
        if (is_shadow) begin
          shadow[address[IW-1:0]] <= writedata[23:0];
        end else if (address == CTRL_ADDR) begin
          if (writedata[0]) pending <= 1'b1;
          if (writedata[1]) shadow  <= '0;
          irq_en <= writedata[2];
        end else if (address == STATUS_ADDR) begin
          if (writedata[0]) irq <= 1'b0;
        end
      end

      if (bus_rd) begin
        readdata <= rd_mux;
        if (address == STATUS_ADDR) irq <= 1'b0;
      end

      if (vb_edge && pending && irq_en) irq <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sprite_table.sv
// Self-checking bench for sprite_table: read data goes through an expected-value queue.
module tb_sprite_table;

  logic              clk = 1'b0;
  logic              reset;
  logic              chipselect;
  logic              write;
  logic              read;
  logic [4:0]        address;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [9:0]        VGA_VCOUNT;
  logic [19:0][23:0] gl_array;
  logic [15:0]       frame_count;
  logic              irq;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic        rd_vld_q = 1'b0;
  logic [15:0] exp_fc = '0;

  sprite_table #(.NUM_SPRITES(20), .V_ACTIVE(480)) dut (
    .clk         (clk),
    .reset       (reset),
    .chipselect  (chipselect),
    .write       (write),
    .read        (read),
    .address     (address),
    .writedata   (writedata),
    .readdata    (readdata),
    .VGA_VCOUNT  (VGA_VCOUNT),
    .gl_array    (gl_array),
    .frame_count (frame_count),
    .irq         (irq)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // One scan line per clock; the expected frame count tracks vblank entries seen out of reset.
  task automatic cyc();
    @(negedge clk);
    if (VGA_VCOUNT == 10'd524) VGA_VCOUNT = 10'd0;
    else                       VGA_VCOUNT = VGA_VCOUNT + 10'd1;
    if (reset && VGA_VCOUNT == 10'd480) exp_fc = exp_fc + 16'd1;
  endtask

  task automatic wait_vc(input logic [9:0] v);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (VGA_VCOUNT != v && n < 1100);
    if (VGA_VCOUNT != v) chk("wait_vc_timeout", 32'(VGA_VCOUNT), 32'(v));
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    cyc();
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    cyc();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd_reg(input logic [4:0] a, input logic [31:0] exp);
    cyc();
    chipselect = 1'b1; read = 1'b1; address = a;
    exp_q.push_back(exp);
    cyc();
    chipselect = 1'b0; read = 1'b0;
  endtask

  always @(posedge clk) rd_vld_q <= chipselect & read & ~write;

  always @(negedge clk) begin
    if (rd_vld_q) begin
      if (exp_q.size() == 0) chk("rd_unexpected", readdata, 32'hxxxx_xxxx);
      else                   chk("rdata", readdata, exp_q.pop_front());
    end
  end

  initial begin
    reset = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = '0; writedata = '0; VGA_VCOUNT = '0;
    repeat (3) cyc();
    chk("rst_gl0",   32'(gl_array[0]), 32'h0);
    chk("rst_gl19",  32'(gl_array[19]), 32'h0);
    chk("rst_fc",    32'(frame_count), 32'h0);
    chk("rst_irq",   32'(irq), 32'h0);
    chk("rst_rdata", readdata, 32'h0);
    reset = 1'b1;

    // Two idle frames
    repeat (1050) cyc();
    chk("idle_fc",  32'(frame_count), 32'd2);
    chk("idle_irq", 32'(irq), 32'h0);
    chk("idle_gl",  32'(gl_array != '0), 32'h0);
    rd_reg(5'd21, 32'h0002_0000);

    // Shadow write without commit
    wr_reg(5'd3, 32'h0012_345A);
    repeat (525) cyc();
    chk("nocommit_gl3", 32'(gl_array[3]), 32'h0);
    rd_reg(5'd3, 32'h0012_345A);

    // Commit with irq enabled
    wait_vc(10'd100);
    wr_reg(5'd0, 32'h000A_0281);
    wr_reg(5'd19, 32'h00FF_FFFF);
    wr_reg(5'd20, 32'h5);
    wait_vc(10'd480);
    chk("pre_swap_gl0",  32'(gl_array[0]), 32'h0);
    chk("pre_swap_gl19", 32'(gl_array[19]), 32'h0);
    cyc();
    chk("swap_gl0",  32'(gl_array[0]), 32'h000A_0281);
    chk("swap_gl19", 32'(gl_array[19]), 32'h00FF_FFFF);
    chk("swap_gl3",  32'(gl_array[3]), 32'h0012_345A);
    chk("swap_irq",  32'(irq), 32'h1);
    rd_reg(5'd20, 32'h4);
    rd_reg(5'd21, {exp_fc, 16'h0002});
    rd_reg(5'd21, {exp_fc, 16'h0000});

    // Commit written exactly on the vblank edge defers one frame
    wr_reg(5'd5, 32'h0000_0111);
    wait_vc(10'd479);
    wr_reg(5'd20, 32'h1);
    chk("late_commit_gl5", 32'(gl_array[5]), 32'h0);
    chk("late_commit_gl0", 32'(gl_array[0]), 32'h000A_0281);
    rd_reg(5'd20, 32'h1);
    // Shadow write on the swap cycle lands in shadow only
    wait_vc(10'd479);
    wr_reg(5'd5, 32'h0000_0222);
    chk("deferred_gl5", 32'(gl_array[5]), 32'h0000_0111);
    chk("deferred_irq", 32'(irq), 32'h0);
    rd_reg(5'd5, 32'h0000_0222);
    rd_reg(5'd20, 32'h0);

    // Clear + commit loads zeros
    wr_reg(5'd20, 32'h7);
    rd_reg(5'd0, 32'h0);
    rd_reg(5'd19, 32'h0);
    wait_vc(10'd480);
    cyc();
    for (int i = 0; i < 20; i++) chk("clr_gl", 32'(gl_array[i]), 32'h0);
    chk("clr_irq", 32'(irq), 32'h1);
    chk("clr_fc", 32'(frame_count), 32'(exp_fc));
    wr_reg(5'd21, 32'h1);
    chk("irq_wr_clear", 32'(irq), 32'h0);

    // Reset mid-vblank with a commit pending
    wr_reg(5'd1, 32'h0000_0ABC);
    wr_reg(5'd20, 32'h5);
    wait_vc(10'd480);
    cyc();
    chk("pre_rst_gl1", 32'(gl_array[1]), 32'h0000_0ABC);
    wr_reg(5'd20, 32'h5);
    rd_reg(5'd1, 32'h0000_0ABC);
    wait_vc(10'd490);
    reset = 1'b0;
    #1;
    chk("mid_rst_gl1",   32'(gl_array[1]), 32'h0);
    chk("mid_rst_fc",    32'(frame_count), 32'h0);
    chk("mid_rst_irq",   32'(irq), 32'h0);
    chk("mid_rst_rdata", readdata, 32'h0);
    exp_fc = '0;
    repeat (3) cyc();
    reset = 1'b1;
    rd_reg(5'd20, 32'h0);
    wait_vc(10'd479);
    cyc();
    chk("post_rst_fc_hold", 32'(frame_count), 32'h0);
    cyc();
    chk("post_rst_fc", 32'(frame_count), 32'd1);
    chk("post_rst_fc_model", 32'(frame_count), 32'(exp_fc));
    chk("post_rst_gl1", 32'(gl_array[1]), 32'h0);

    repeat (2) cyc();
    chk("rd_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
